// File: rtl/imm_enc_if.sv
// imm_enc_if: request/response bundle for the immediate encoder.
//
// Request side : in_valid, in_ready, ImmSel, immediate, base
// Response side: out_valid, out_ready, instruction, range_err
// Statistics   : enc_count, err_count (constant 0 unless the encoder is
//                built with IMM_ENC_STATS_EN)
//
// master: the requester / result consumer.
// slave : the encoder itself.
interface imm_enc_if #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ImmSel;
  logic [DWIDTH-1:0]    immediate;
  logic [31:0]          base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instruction;
  logic                 range_err;
  logic [CNT_WIDTH-1:0] enc_count;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output in_valid, ImmSel, immediate, base, out_ready,
    input  in_ready, out_valid, instruction, range_err, enc_count, err_count
  );

  modport slave (
    input  in_valid, ImmSel, immediate, base, out_ready,
    output in_ready, out_valid, instruction, range_err, enc_count, err_count
  );
endinterface

// File: rtl/imm_enc.sv
// imm_enc: RISC-V immediate encoder (inverse of the immediate generator).
//
// Scatters a 32-bit immediate into the immediate fields of the format
// selected by ImmSel, taking all other bits from the base template, and
// flags immediates that the format cannot represent. Two-stage valid/ready
// pipeline: S1 holds the encoded word, S2 is the output register.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset, discards in-flight entries
//   bus  - imm_enc_if.slave (request, response and statistics signals)
//
// Build option: define IMM_ENC_STATS_EN to build the saturating transfer
// and error counters; otherwise enc_count/err_count are tied to 0.
module imm_enc #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  imm_enc_if.slave  bus
);

  localparam logic [2:0] SEL_I  = 3'd0;
  localparam logic [2:0] SEL_S  = 3'd1;
  localparam logic [2:0] SEL_SB = 3'd2;
  localparam logic [2:0] SEL_U  = 3'd3;
  localparam logic [2:0] SEL_UJ = 3'd4;
  localparam logic [2:0] SEL_SH = 3'd5;

  logic [DWIDTH-1:0] imm;
  logic [31:0]       tpl;
  logic [31:0]       enc_inst;
  logic              enc_err;

  logic              s1_valid_reg;
  logic [31:0]       s1_inst_reg;
  logic              s1_err_reg;
  logic              s2_valid_reg;
  logic [31:0]       s2_inst_reg;
  logic              s2_err_reg;

  logic              s2_adv;
  logic              s1_adv;
  logic              out_xfer;

  assign imm = bus.immediate;
  assign tpl = bus.base;

  // ---------------------------------------------------------------------
  // Field scatter and range check. Out-of-range values are still scattered
  // from their truncated bits so the caller sees exactly what was mapped.
  // A "sign run" check means every listed bit equals the top bit, i.e. the
  // value sign-extends cleanly from the format's immediate width.
  // ---------------------------------------------------------------------
  always_comb begin
    enc_inst = tpl;
    enc_err  = 1'b1;
    case (bus.ImmSel)
      SEL_I: begin
        enc_inst = {imm[11:0], tpl[19:0]};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_S: begin
        enc_inst = {imm[11:5], tpl[24:12], imm[4:0], tpl[6:0]};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_SB: begin
        enc_inst = {imm[12], imm[10:5], tpl[24:12], imm[4:1], imm[11], tpl[6:0]};
        enc_err  = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      end
      SEL_U: begin
        enc_inst = {imm[31:12], tpl[11:0]};
        enc_err  = |imm[11:0];
      end
      SEL_UJ: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], tpl[11:0]};
        enc_err  = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      SEL_SH: begin
        // funct7 in [31:25] distinguishes SRAI from SRLI, so it stays.
        enc_inst = {tpl[31:25], imm[4:0], tpl[19:0]};
        enc_err  = |imm[31:5];
      end
      default: begin
        enc_inst = tpl;
        enc_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline control. S2 can take a new value whenever it is empty or its
  // current value is leaving; S1 can take a request whenever it is empty or
  // its content is moving into S2. in_ready therefore reduces to
  // !s1_valid || !s2_valid || out_ready.
  // ---------------------------------------------------------------------
  assign s2_adv   = !s2_valid_reg || bus.out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign out_xfer = s2_valid_reg && bus.out_ready;

  assign bus.in_ready    = s1_adv;
  assign bus.out_valid   = s2_valid_reg;
  assign bus.instruction = s2_inst_reg;
  assign bus.range_err   = s2_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_inst_reg  <= '0;
      s1_err_reg   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_inst_reg <= enc_inst;
        s1_err_reg  <= enc_err;
      end
    end
  end

  // Data only changes on a real load, so a drained S2 keeps its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_inst_reg  <= '0;
      s2_err_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_inst_reg <= s1_inst_reg;
        s2_err_reg  <= s1_err_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics: counter 0 counts every output transfer, counter 1 only the
  // transfers flagged with range_err. Both stick at all-ones.
  // ---------------------------------------------------------------------
`ifdef IMM_ENC_STATS_EN
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = out_xfer;
  assign cnt_inc[1] = out_xfer && s2_err_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign bus.enc_count = g_cnt[0].cnt_reg;
  assign bus.err_count = g_cnt[1].cnt_reg;
`else
  logic unused_xfer;
  assign unused_xfer   = out_xfer;
  assign bus.enc_count = '0;
  assign bus.err_count = '0;
`endif

endmodule
